// File: rtl/circuito.sv
// Combination-lock sequence checker: four 8-bit codes in consecutive clocks open
// the lock; a wrong code after the first one latches ERROR until reset.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | 0000, waiting for the first code (0x8C); mismatches hold here
// S1    | 0101, first code accepted, expecting 0x5A
// S2    | 0110, second code accepted, expecting 0xA5
// S3    | 0111, third code accepted, expecting 0x3C
// OPEN  | 1111, unlocked; holds until reset
// ERROR | 1000, wrong entry; holds until reset
module circuito (
    input  logic clk,
    input  logic reset,
    input  logic b8,
    input  logic b7,
    input  logic b6,
    input  logic b5,
    input  logic b4,
    input  logic b3,
    input  logic b2,
    input  logic b1,
    output logic a,
    output logic b,
    output logic c,
    output logic d
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0000,
        S1    = 4'b0101,
        S2    = 4'b0110,
        S3    = 4'b0111,
        OPEN  = 4'b1111,
        ERROR = 4'b1000
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] w;

    assign w = {b8, b7, b6, b5, b4, b3, b2, b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Unused 4-bit encodings fall through to the default and land in ERROR.
    always_comb begin
        state_nxt = ERROR;
        case (state)
            IDLE:    state_nxt = (w == 8'h8C) ? S1   : IDLE;
            S1:      state_nxt = (w == 8'h5A) ? S2   : ERROR;
            S2:      state_nxt = (w == 8'hA5) ? S3   : ERROR;
            S3:      state_nxt = (w == 8'h3C) ? OPEN : ERROR;
            OPEN:    state_nxt = OPEN;
            ERROR:   state_nxt = ERROR;
            default: state_nxt = ERROR;
        endcase
    end

    assign {a, b, c, d} = state;

endmodule

// File: tb/tb_circuito.sv
// Directed bench for the combination-lock checker: each step applies one code
// word (and reset) for one clock and checks the registered state code.
module tb_circuito;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic b8 = 1'b0, b7 = 1'b0, b6 = 1'b0, b5 = 1'b0;
    logic b4 = 1'b0, b3 = 1'b0, b2 = 1'b0, b1 = 1'b0;
    logic a, b, c, d;

    int total = 0;
    int bad = 0;

    circuito dut (
        .clk   (clk),
        .reset (reset),
        .b8    (b8),
        .b7    (b7),
        .b6    (b6),
        .b5    (b5),
        .b4    (b4),
        .b3    (b3),
        .b2    (b2),
        .b1    (b1),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic [7:0] wv,
                        input logic [3:0] exp, input string tag);
        logic [3:0] got;
        reset = rst;
        {b8, b7, b6, b5, b4, b3, b2, b1} = wv;
        @(posedge clk);
        #1;
        got = {a, b, c, d};
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    initial begin
        logic [7:0] wrong [3];
        wrong[0] = 8'hEB;
        wrong[1] = 8'hCF;
        wrong[2] = 8'h32;

        @(negedge clk);
        step(1'b1, 8'hCF, 4'b0000, "reset_w_cf");
        step(1'b0, 8'h8C, 4'b0101, "idle_to_s1");
        step(1'b0, 8'hD8, 4'b1000, "s1_wrong_d8");
        step(1'b0, 8'h8C, 4'b1000, "error_holds");
        step(1'b1, 8'h8C, 4'b0000, "reset_from_error");

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h8C,    4'b0101, "wrong_loop_s1");
            step(1'b0, wrong[i], 4'b1000, "wrong_loop_error");
            step(1'b1, 8'h00,    4'b0000, "wrong_loop_reset");
        end
        step(1'b0, 8'h8C, 4'b0101, "after_loop_s1");
        step(1'b1, 8'h00, 4'b0000, "reset_from_s1");

        step(1'b0, 8'h8C, 4'b0101, "seq_s1");
        step(1'b0, 8'h5A, 4'b0110, "seq_s2");
        step(1'b0, 8'hA5, 4'b0111, "seq_s3");
        step(1'b0, 8'h3C, 4'b1111, "seq_open");
        step(1'b0, 8'h00, 4'b1111, "open_hold_00");
        step(1'b0, 8'hFF, 4'b1111, "open_hold_ff");
        step(1'b0, 8'h8C, 4'b1111, "open_hold_8c");
        step(1'b0, 8'h5A, 4'b1111, "open_hold_5a");
        step(1'b1, 8'h8C, 4'b0000, "reset_from_open");

        step(1'b0, 8'h00, 4'b0000, "idle_hold_00");
        step(1'b0, 8'hFF, 4'b0000, "idle_hold_ff");
        step(1'b0, 8'h8D, 4'b0000, "idle_hold_8d");
        step(1'b0, 8'h8C, 4'b0101, "held_code_first");
        step(1'b0, 8'h8C, 4'b1000, "held_code_second");
        step(1'b1, 8'h00, 4'b0000, "reset_after_held");

        step(1'b0, 8'h8C, 4'b0101, "mid_s1");
        step(1'b0, 8'h5A, 4'b0110, "mid_s2");
        step(1'b1, 8'hA5, 4'b0000, "reset_in_s2");
        step(1'b0, 8'hA5, 4'b0000, "no_resume_after_reset");

        step(1'b0, 8'h8C, 4'b0101, "s2_wrong_s1");
        step(1'b0, 8'h5A, 4'b0110, "s2_wrong_s2");
        step(1'b0, 8'h5A, 4'b1000, "s2_held_prev_code");
        step(1'b1, 8'h00, 4'b0000, "reset_s2_case");

        step(1'b0, 8'h8C, 4'b0101, "s3_wrong_s1");
        step(1'b0, 8'h5A, 4'b0110, "s3_wrong_s2");
        step(1'b0, 8'hA5, 4'b0111, "s3_wrong_s3");
        step(1'b0, 8'h3D, 4'b1000, "s3_near_miss_3d");
        step(1'b1, 8'h3C, 4'b0000, "reset_s3_case");

        step(1'b0, 8'h8C, 4'b0101, "s1_near_miss_s1");
        step(1'b0, 8'hDA, 4'b1000, "s1_near_miss_da");
        step(1'b1, 8'h8C, 4'b0000, "reset_with_valid_code");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
